encoder_odometer: RTL and testbench
===================================

// Module: encoder_odometer
// PURPOSE
//   Front end of the taxi meter. Conditions the raw wheel-encoder input: 2-flop synchroniser, glitch filter, rising-edge detect.
//   Runs the trip state machine from the debounced launch/step key flags and accumulates distance units.
//   Its distance and tick outputs feed the price and BCD display stages downstream.
// PARAMETERS
//   FILT_CNT        20'd49   cycles input must differ from filtered level, minus 1, before level flips (1 us @50 MHz)
//   PULSES_PER_UNIT 16'd100  filtered encoder rising edges per distance unit (>=1)
//   DIST_W          20       width of distance output
//   DIST_MAX        20'd999  saturation value of distance (3-digit display)
// PORTS
//   sys_clk          in   1       system clock, all logic on rising edge
//   sys_rst          in   1       asynchronous, active-high reset
//   encoder_pulses   in   1       raw encoder square wave, asynchronous to sys_clk
//   flag_key_launch  in   1       1-cycle debounced launch key flag
//   flag_key_step    in   1       1-cycle debounced step (end-trip) key flag
//   run              out  1       1 while state==RUN
//   dist_tick        out  1       1-cycle pulse per completed distance unit
//   distance         out  DIST_W  trip distance in units, binary
//   dist_sat         out  1       distance has reached DIST_MAX
// BEHAVIOUR
//   Reset (async, immediate)
//     sync flops=0, filtered level=0, filter cnt=0, sub cnt=0, state=IDLE.
//     run=0, dist_tick=0, distance=0, dist_sat=0.
//   Filter
//     Filtered level flips only after the synchronised input differs from it for FILT_CNT+1 consecutive cycles.
//     Any agreeing cycle clears the filter counter.
//     Event = filtered level 0->1 (registered edge detect).
//     Latency raw edge -> event cycle = 2 + FILT_CNT+1 + 1 clocks.
//     The filter runs in all states.
//   FSM: IDLE / RUN / PAUSE; all outputs registered.
//     IDLE : launch -> RUN; distance, sub cnt, dist_sat cleared to 0 on that edge.
//            Distance otherwise holds last trip value.
//     RUN  : launch -> PAUSE; step -> IDLE.
//     PAUSE: launch -> RUN; step -> IDLE. Sub cnt and distance retained.
//     launch and step in the same cycle: step wins (IDLE, distance held).
//     step in IDLE: no effect.
//   Counting (RUN only; events in IDLE/PAUSE are discarded)
//     Event with sub cnt < PULSES_PER_UNIT-1: sub cnt +1.
//     Event with sub cnt == PULSES_PER_UNIT-1: sub cnt=0, distance+1, dist_tick=1.
//       Distance and tick change on the same clock edge, one clock after the event cycle.
//     Event in the same cycle as a state-changing key: key takes priority, event dropped.
//     distance == DIST_MAX: no further increment or dist_tick, dist_sat=1.
//       Sub cnt keeps wrapping. Cleared only by launch from IDLE or reset.
//     Saturation applies to distance only; no wrap-around.
//   dist_tick is never high for 2 consecutive cycles. run follows state one clock after the key flag.
// TESTING (bench params: FILT_CNT=3, PULSES_PER_UNIT=4, DIST_MAX=5)
//   1. RUN, encoder high 3 cycles then low, then high 10 cycles
//      -> glitch gives no event; long pulse gives exactly 1 event (sub cnt=1).
//   2. Launch, then 8 clean pulses (10 high/10 low)
//      -> distance=2, exactly 2 single-cycle dist_tick pulses aligned with increments.
//   3. Launch, 2 pulses, launch (PAUSE), 5 pulses, launch (RUN), 2 pulses
//      -> distance=1, run=0 during pause.
//   4. Launch, 30 pulses -> distance=5, dist_sat=1, exactly 5 ticks total.
//      Then step, then launch -> distance=0, dist_sat=0.
//   5. RUN with distance=3; launch+step in the same cycle
//      -> state IDLE, run=0, distance stays 3. Further pulses do not change distance.
//   6. Assert sys_rst mid-pulse, between clock edges, with distance=2
//      -> all outputs 0 immediately. After release, launch + 4 pulses -> distance=1.

Source files
------------

// File: rtl/encoder_odometer.sv
// Taxi-meter front end: conditions the raw wheel-encoder input, runs the
// trip state machine from the launch/step key flags, and accumulates
// distance units for the downstream price and display stages.
module encoder_odometer #(
    parameter logic [19:0]       FILT_CNT        = 20'd49,
    parameter logic [15:0]       PULSES_PER_UNIT = 16'd100,
    parameter int unsigned       DIST_W          = 20,
    parameter logic [DIST_W-1:0] DIST_MAX        = DIST_W'(999)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              encoder_pulses,
    input  logic              flag_key_launch,
    input  logic              flag_key_step,
    output logic              run,
    output logic              dist_tick,
    output logic [DIST_W-1:0] distance,
    output logic              dist_sat
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t            state, next_state;
    logic              sync_0, sync_1;
    logic              filt_level, filt_prev, enc_event;
    logic [19:0]       filt_cnt;
    logic [15:0]       sub_cnt, sub_nxt;
    logic [DIST_W-1:0] dist_nxt, dist_inc;
    logic              sat_nxt, tick_nxt;

    // Two-flop synchroniser for the asynchronous encoder input
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= encoder_pulses;
            sync_1 <= sync_0;
        end
    end

    // Glitch filter: level follows the input only after FILT_CNT+1 disagreeing cycles
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            filt_level <= 1'b0;
            filt_cnt   <= '0;
        end else if (sync_1 != filt_level) begin
            if (filt_cnt == FILT_CNT) begin
                filt_level <= sync_1;
                filt_cnt   <= '0;
            end else begin
                filt_cnt <= filt_cnt + 20'd1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Registered rising-edge detect on the filtered level
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            filt_prev <= 1'b0;
            enc_event <= 1'b0;
        end else begin
            filt_prev <= filt_level;
            enc_event <= filt_level & ~filt_prev;
        end
    end

    // Trip state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic; step overrides launch when both arrive together
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (flag_key_launch && !flag_key_step) next_state = RUN;
            RUN:     if (flag_key_step) next_state = IDLE;
                     else if (flag_key_launch) next_state = PAUSE;
            PAUSE:   if (flag_key_step) next_state = IDLE;
                     else if (flag_key_launch) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the counting datapath; events count only while staying in RUN
    always_comb begin
        sub_nxt  = sub_cnt;
        dist_nxt = distance;
        sat_nxt  = dist_sat;
        tick_nxt = 1'b0;
        dist_inc = distance + DIST_W'(1);
        if (state == IDLE && next_state == RUN) begin
            sub_nxt  = '0;
            dist_nxt = '0;
            sat_nxt  = 1'b0;
        end else if (state == RUN && next_state == RUN && enc_event) begin
            if (sub_cnt == PULSES_PER_UNIT - 16'd1) begin
                sub_nxt = '0;
                if (distance != DIST_MAX) begin
                    dist_nxt = dist_inc;
                    tick_nxt = 1'b1;
                    sat_nxt  = (dist_inc == DIST_MAX);
                end
            end else begin
                sub_nxt = sub_cnt + 16'd1;
            end
        end
    end

    // Registered outputs and counters
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            run       <= 1'b0;
            dist_tick <= 1'b0;
            distance  <= '0;
            dist_sat  <= 1'b0;
            sub_cnt   <= '0;
        end else begin
            run       <= (next_state == RUN);
            dist_tick <= tick_nxt;
            distance  <= dist_nxt;
            dist_sat  <= sat_nxt;
            sub_cnt   <= sub_nxt;
        end
    end

endmodule

// File: tb/tb_encoder_odometer.sv
// Scoreboard bench for encoder_odometer: a trip-level model predicts each
// distance increment, and a monitor checks every dist_tick against it.
module tb_encoder_odometer;

    localparam int PPU  = 4;
    localparam int DMAX = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enc = 1'b0;
    logic        launch = 1'b0;
    logic        step = 1'b0;
    logic        run, dist_tick, dist_sat;
    logic [19:0] distance;

    int checks = 0;
    int errors = 0;

    // Model: trip mode 0=idle 1=running 2=paused, pulses into unit, units, saturated
    int m_mode = 0;
    int m_sub  = 0;
    int m_dist = 0;
    int m_sat  = 0;
    int exp_q[$];
    logic prev_tick = 1'b0;

    encoder_odometer #(
        .FILT_CNT(20'd3),
        .PULSES_PER_UNIT(16'd4),
        .DIST_W(20),
        .DIST_MAX(20'd5)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .encoder_pulses(enc),
        .flag_key_launch(launch),
        .flag_key_step(step),
        .run(run),
        .dist_tick(dist_tick),
        .distance(distance),
        .dist_sat(dist_sat)
    );

    always #5 clk = ~clk;

    // Monitor: every tick must match the next predicted increment
    always @(negedge clk) begin
        if (rst) begin
            prev_tick = 1'b0;
        end else begin
            if (dist_tick) begin
                checks++;
                if (prev_tick) begin
                    errors++;
                    $display("FAIL tick_width: dist_tick high on consecutive cycles, want single-cycle");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected: got tick with distance=%0d, want no tick", distance);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(distance) != e || int'(dist_sat) != int'(e == DMAX)) begin
                        errors++;
                        $display("FAIL tick_value: got distance=%0d sat=%0d, want distance=%0d sat=%0d",
                                 distance, dist_sat, e, int'(e == DMAX));
                    end
                end
            end
            prev_tick = dist_tick;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name);
        checks++;
        if (int'(run) != int'(m_mode == 1) || int'(distance) != m_dist || int'(dist_sat) != m_sat) begin
            errors++;
            $display("FAIL %s: got run=%0d distance=%0d sat=%0d, want run=%0d distance=%0d sat=%0d",
                     name, run, distance, dist_sat, int'(m_mode == 1), m_dist, m_sat);
        end
    endtask

    // One filtered encoder event as seen by the trip model
    task automatic model_event();
        if (m_mode == 1) begin
            if (m_sub == PPU - 1) begin
                m_sub = 0;
                if (m_dist != DMAX) begin
                    m_dist++;
                    m_sat = int'(m_dist == DMAX);
                    exp_q.push_back(m_dist);
                end
            end else begin
                m_sub++;
            end
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        model_event();
        enc = 1'b1;
        cyc(hi);
        enc = 1'b0;
        cyc(lo);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse(10, 10);
    endtask

    task automatic glitch(input int hi);
        enc = 1'b1;
        cyc(hi);
        enc = 1'b0;
        cyc(8);
    endtask

    task automatic keys(input logic l, input logic s);
        launch = l;
        step   = s;
        cyc(1);
        launch = 1'b0;
        step   = 1'b0;
        if (s) begin
            m_mode = 0;
        end else if (l) begin
            if (m_mode == 0) begin
                m_mode = 1; m_sub = 0; m_dist = 0; m_sat = 0;
            end else begin
                m_mode = (m_mode == 1) ? 2 : 1;
            end
        end
        cyc(3);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (run !== 1'b0 || dist_tick !== 1'b0 || distance !== 20'd0 || dist_sat !== 1'b0) begin
            errors++;
            $display("FAIL %s: got run=%0d tick=%0d distance=%0d sat=%0d, want all 0",
                     name, run, dist_tick, distance, dist_sat);
        end
    endtask

    initial begin
        // Power-on reset takes effect before any clock edge
        #1 rst = 1'b1;
        #2 check_zero("reset_async");
        cyc(3);
        rst = 1'b0;
        cyc(2);
        check_zero("reset_state");

        // Glitch rejected, long pulse gives one event
        keys(1'b1, 1'b0);
        check_state("launch_run");
        glitch(3);
        check_state("glitch");
        pulse(10, 10);
        check_state("long_pulse");
        pulses(3);
        check_state("first_unit");

        // Fresh trip: 8 pulses -> 2 units
        keys(1'b0, 1'b1);
        check_state("step_idle");
        keys(1'b1, 1'b0);
        check_state("relaunch_clear");
        pulses(8);
        check_state("two_units");

        // Pause discards pulses and retains sub count
        keys(1'b0, 1'b1);
        keys(1'b1, 1'b0);
        pulses(2);
        keys(1'b1, 1'b0);
        check_state("paused");
        pulses(5);
        check_state("pause_pulses");
        keys(1'b1, 1'b0);
        pulses(2);
        check_state("resume");

        // Saturation then clear by new trip
        keys(1'b0, 1'b1);
        keys(1'b1, 1'b0);
        pulses(30);
        check_state("saturated");
        keys(1'b0, 1'b1);
        check_state("sat_held_idle");
        keys(1'b1, 1'b0);
        check_state("sat_cleared");

        // Launch and step together: step wins, distance held
        pulses(12);
        check_state("three_units");
        keys(1'b1, 1'b1);
        check_state("both_keys");
        pulses(4);
        check_state("idle_pulses");
        keys(1'b0, 1'b1);
        check_state("step_in_idle");

        // Reset mid-pulse between clock edges
        keys(1'b1, 1'b0);
        pulses(8);
        check_state("pre_reset");
        enc = 1'b1;
        cyc(2);
        #3 rst = 1'b1;
        #1 check_zero("reset_mid_pulse");
        enc = 1'b0;
        m_mode = 0; m_sub = 0; m_dist = 0; m_sat = 0;
        exp_q.delete();
        cyc(3);
        rst = 1'b0;
        cyc(10);
        keys(1'b1, 1'b0);
        pulses(4);
        check_state("after_reset");

        // Randomized trips
        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 5)      pulse(int'($urandom_range(5, 12)), int'($urandom_range(8, 12)));
            else if (op == 6) glitch(int'($urandom_range(1, 3)));
            else if (op == 7) keys(1'b1, 1'b0);
            else if (op == 8) keys(1'b0, 1'b1);
            else              keys(1'b1, 1'b1);
            check_state("random_op");
        end

        cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_ticks: got %0d predicted ticks never seen, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
